// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state codes, frame defaults and line level for the UART TX arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int DATA_BITS_DEF = 8;
  localparam int STOP_BITS_DEF = 1;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_shift.sv
// rtl/uart_tx_shift.sv - frame serialiser: shift register, bit/stop counters and the registered tx line
module uart_tx_shift
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_en,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  state_t               state,
  output logic                 tx,
  output logic                 last_bit,
  output logic                 last_stop
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= LINE_IDLE;
    end else if (load) begin
      shreg    <= load_data;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (baud_en) begin
      case (state)
        ST_ARM:   tx <= 1'b0;
        ST_START: begin
          tx      <= shreg[0];
          bit_cnt <= '0;
        end
        // tx takes the bit that becomes shreg[0] after this shift
        ST_DATA: begin
          if (bit_cnt != LAST_BIT) begin
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            tx       <= LINE_IDLE;
            stop_cnt <= 1'b0;
          end
        end
        ST_STOP: begin
          if (stop_cnt != LAST_STOP) stop_cnt <= stop_cnt + 1'b1;
        end
        default:  tx <= LINE_IDLE;
      endcase
    end
  end

  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_stop = (stop_cnt == LAST_STOP);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one baud-timed UART tx line between two byte requesters
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_en,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  state_t               state;
  state_t               state_nxt;
  logic                 last_grant;
  logic                 grant;
  logic                 winner;
  logic [DATA_BITS-1:0] win_data;
  logic                 last_bit;
  logic                 last_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req0 || req1)           state_nxt = ST_ARM;
      ST_ARM:   if (baud_en)                state_nxt = ST_START;
      ST_START: if (baud_en)                state_nxt = ST_DATA;
      ST_DATA:  if (baud_en && last_bit)    state_nxt = ST_STOP;
      ST_STOP:  if (baud_en && last_stop)   state_nxt = ST_IDLE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  // A tie goes to whichever requester did not win last time.
  always_comb begin
    grant    = (state == ST_IDLE) && (req0 || req1);
    winner   = (req0 && req1) ? ~last_grant : req1;
    win_data = winner ? data1 : data0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack0 <= grant && !winner;
      ack1 <= grant && winner;
      if (grant) begin
        grant_id   <= winner;
        last_grant <= winner;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  uart_tx_shift #(
    .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .baud_en   (baud_en),
    .load      (grant),
    .load_data (win_data),
    .state     (state),
    .tx        (tx),
    .last_bit  (last_bit),
    .last_stop (last_stop)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench for uart_tx_arbiter against a frame-level reference model
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_en;
  logic       req0 [2];
  logic       req1 [2];
  logic [7:0] d0_a, d1_a;
  logic [6:0] d0_b, d1_b;
  logic       ack0_o [2];
  logic       ack1_o [2];
  logic       tx_o [2];
  logic       busy_o [2];
  logic       gid_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .baud_en(baud_en),
    .req0(req0[0]), .data0(d0_a), .ack0(ack0_o[0]),
    .req1(req1[0]), .data1(d1_a), .ack1(ack1_o[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0])
  );

  uart_tx_arbiter #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .baud_en(baud_en),
    .req0(req0[1]), .data0(d0_b), .ack0(ack0_o[1]),
    .req1(req1[1]), .data1(d1_b), .ack1(ack1_o[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1])
  );

  // model: a granted frame is the list of line levels {start, data LSB first, stops}
  int   db [2] = '{8, 7};
  int   sb [2] = '{1, 2};
  logic m_busy [2], m_tx [2], m_last [2], m_gid [2], e_ack0 [2], e_ack1 [2];
  logic m_frame [2][16];
  int   m_idx [2], m_len [2];
  int   acks_seen [2];

  logic [7:0] qmem [2][2][32];
  int         qhead [2][2];
  int         qtail [2][2];
  int         gate_pct;
  int         baud_gap_max;
  bit         baud_fixed;
  int         baud_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cur_data(int k, int r);
    if (k == 0) return (r != 0) ? d1_a : d0_a;
    return (r != 0) ? {1'b0, d1_b} : {1'b0, d0_b};
  endfunction

  task automatic model_step(int k);
    logic       w;
    logic [7:0] byt;
    e_ack0[k] = 1'b0;
    e_ack1[k] = 1'b0;
    if (!reset) begin
      m_busy[k] = 1'b0; m_tx[k] = 1'b1; m_last[k] = 1'b1; m_gid[k] = 1'b0; m_idx[k] = 0;
    end else if (!m_busy[k]) begin
      if (req0[k] || req1[k]) begin
        w = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
        m_last[k] = w;
        m_gid[k]  = w;
        if (w) e_ack1[k] = 1'b1; else e_ack0[k] = 1'b1;
        byt = cur_data(k, w ? 1 : 0);
        for (int i = 0; i < 16; i++) m_frame[k][i] = 1'b1;
        m_frame[k][0] = 1'b0;
        for (int i = 0; i < db[k]; i++) m_frame[k][1+i] = byt[i];
        m_len[k]  = 1 + db[k] + sb[k];
        m_idx[k]  = 0;
        m_busy[k] = 1'b1;
      end
    end else if (baud_en) begin
      if (m_idx[k] < m_len[k]) begin
        m_tx[k] = m_frame[k][m_idx[k]];
        m_idx[k]++;
      end else begin
        m_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic compare(int k);
    check_eq($sformatf("tx[%0d]", k),   tx_o[k],   m_tx[k]);
    check_eq($sformatf("busy[%0d]", k), busy_o[k], m_busy[k]);
    check_eq($sformatf("ack0[%0d]", k), ack0_o[k], e_ack0[k]);
    check_eq($sformatf("ack1[%0d]", k), ack1_o[k], e_ack1[k]);
    check_eq($sformatf("gid[%0d]", k),  gid_o[k],  m_gid[k]);
    if (ack0_o[k] === 1'b1) acks_seen[k]++;
    if (ack1_o[k] === 1'b1) acks_seen[k]++;
  endtask

  task automatic agent(int k, int r);
    logic acked, cur_req, pending;
    acked   = (r == 0) ? e_ack0[k] : e_ack1[k];
    cur_req = (r == 0) ? req0[k] : req1[k];
    if (acked) qhead[k][r]++;
    pending = qhead[k][r] < qtail[k][r];
    if (!pending) cur_req = 1'b0;
    else if (!cur_req && ($urandom_range(0, 99) < gate_pct)) cur_req = 1'b1;
    if (r == 0) req0[k] = cur_req; else req1[k] = cur_req;
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++) agent(k, r);
    d0_a = (qhead[0][0] < qtail[0][0]) ? qmem[0][0][qhead[0][0]] : 8'($urandom);
    d1_a = (qhead[0][1] < qtail[0][1]) ? qmem[0][1][qhead[0][1]] : 8'($urandom);
    d0_b = (qhead[1][0] < qtail[1][0]) ? qmem[1][0][qhead[1][0]][6:0] : 7'($urandom);
    d1_b = (qhead[1][1] < qtail[1][1]) ? qmem[1][1][qhead[1][1]][6:0] : 7'($urandom);
    if (baud_cnt == 0) begin
      baud_en  = 1'b1;
      baud_cnt = baud_fixed ? baud_gap_max : int'($urandom_range(0, baud_gap_max));
    end else begin
      baud_en = 1'b0;
      baud_cnt--;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      compare(k);
    end
    drive();
  endtask

  task automatic push(int k, int r, logic [7:0] v);
    qmem[k][r][qtail[k][r]] = (k == 1) ? (v & 8'h7f) : v;
    qtail[k][r]++;
  endtask

  function automatic bit all_idle();
    bit idle = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] || req0[k] || req1[k]) idle = 1'b0;
      for (int r = 0; r < 2; r++) if (qhead[k][r] < qtail[k][r]) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic run_until_idle(input string tag, int limit);
    int n = 0;
    cycle();
    while (!all_idle() && n < limit) begin
      cycle();
      n++;
    end
    check_eq(tag, (n < limit) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    baud_en = 1'b0;
    d0_a = '0; d1_a = '0; d0_b = '0; d1_b = '0;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; acks_seen[k] = 0;
      m_busy[k] = 1'b0; m_tx[k] = 1'b1; m_last[k] = 1'b1; m_gid[k] = 1'b0;
      m_idx[k] = 0; m_len[k] = 0; e_ack0[k] = 1'b0; e_ack1[k] = 1'b0;
      for (int r = 0; r < 2; r++) begin qhead[k][r] = 0; qtail[k][r] = 0; end
    end
    gate_pct = 100; baud_gap_max = 3; baud_fixed = 1'b1; baud_cnt = 3;

    repeat (3) cycle();
    reset = 1'b1;

    // single requester, fixed baud grid
    push(0, 0, 8'hA5);
    push(1, 1, 8'h55);
    run_until_idle("drain_single", 400);

    // both requesters held high across four frames
    push(0, 0, 8'h11); push(0, 1, 8'h22); push(0, 0, 8'h33); push(0, 1, 8'h44);
    push(1, 0, 8'h11); push(1, 1, 8'h22); push(1, 0, 8'h33); push(1, 1, 8'h44);
    run_until_idle("drain_tie", 800);

    // random bytes, random request timing, random baud gaps including every clk
    gate_pct = 30; baud_fixed = 1'b0; baud_gap_max = 5;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 8; i++) push(k, r, 8'($urandom));
    run_until_idle("drain_random", 8000);

    // reset asserted during data bit 3
    gate_pct = 100; baud_fixed = 1'b1; baud_gap_max = 3;
    push(0, 0, 8'h3C);
    push(1, 1, 8'h2A);
    n = 0;
    while (!(m_busy[0] && m_idx[0] == 5) && n < 200) begin
      cycle();
      n++;
    end
    check_eq("reach_bit3", (n < 200) ? 1 : 0, 1);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("async_tx[%0d]", k),   tx_o[k],   1'b1);
      check_eq($sformatf("async_busy[%0d]", k), busy_o[k], 1'b0);
    end
    repeat (3) cycle();
    reset = 1'b1;
    repeat (40) cycle();

    for (int k = 0; k < 2; k++)
      check_eq($sformatf("ack_count[%0d]", k), acks_seen[k], qtail[k][0] + qtail[k][1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between two byte requesters. Round-robin arbitration picks a requester and latches its byte. The byte is then serialised as a start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits, one bit per pulse of the external baud enable from the existing uart_clk_en divider. This block is the scheduler between the producers and the shared baud-timed line.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5-8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; all state cleared while low
baud_en  in  1  one-clk pulse per bit period, from uart_clk_en
req0  in  1  requester 0 holds high until ack0
data0  in  DATA_BITS  requester 0 byte; must be valid while req0 is high
ack0  out  1  one-clk pulse; data0 is sampled in this cycle
req1  in  1  requester 1 holds high until ack1
data1  in  DATA_BITS  requester 1 byte
ack1  out  1  one-clk pulse; data1 is sampled in this cycle
tx  out  1  serial line; idle high; registered
busy  out  1  high from the grant cycle through the end of the last stop bit
grant_id  out  1  requester of the current or most recent frame

Behaviour:
- Reset values (reset low, asynchronous): tx=1, busy=0, ack0=ack1=0, grant_id=0, state=IDLE, last_grant=1, so req0 wins the first tie.
- Reset asserted mid-frame: tx returns to 1 at once. The frame is abandoned and no ack is reissued.
- States: IDLE, ARM, START, DATA, STOP.
- IDLE, arbitration:
  - If any req is high, grant in this cycle.
  - One req high: that requester wins.
  - Both high: the requester other than last_grant wins.
  - In the grant cycle: ack pulses for one clk, the shift register loads the winner's data, grant_id and last_grant are updated, busy goes 1, next state is ARM.
  - baud_en in the grant cycle is ignored.
- ARM: on baud_en, tx<=0 and next state is START. This aligns the start bit to the baud grid.
- START: on baud_en, tx<=bit0 and next state is DATA; bit counter = 0.
- DATA:
  - On baud_en, if counter < DATA_BITS-1: shift, tx<=next bit, counter+1.
  - On baud_en, otherwise: tx<=1, next state is STOP; stop counter = 0.
- STOP:
  - On baud_en, if stop counter = STOP_BITS-1: next state is IDLE, busy<=0.
  - Otherwise: stop counter+1; tx stays 1.
- The earliest next grant is the clk after the IDLE return. Back-to-back frames therefore lose only the ARM wait, at most one baud period.
- Frame length, measured from the first baud_en after grant: 1+DATA_BITS+STOP_BITS baud periods, exact.
- A req that falls before its ack is a protocol violation. The block takes no defined action.
- A req still high the clk after ack is treated as a new request.
- Changes on req or data outside IDLE are ignored.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, ARM, START, DATA, STOP) as a 3-bit code;
  - the DATA_BITS and STOP_BITS defaults;
  - the idle line level constant (1).
- Natural sub-module: uart_tx_shift, which holds the shift register, bit and stop counters and tx register, stepped by baud_en plus a load strobe.
- The arbiter and handshake logic stay in uart_tx_arbiter.

Test Plan:
1. Reset low for 3 clks, then high, baud_en every 4 clks, req0=1, data0=8'hA5 -> ack0 pulses once, 1 clk after req0 seen. tx sequence per baud period: 0,1,0,1,0,0,1,0,1,1. busy falls after the stop bit; grant_id=0.
2. req0 and req1 raised in the same clk, data0=8'h11, data1=8'h22 -> ack0 first, frame 8'h11. ack1 is granted the clk after the frame returns to IDLE, frame 8'h22. grant_id goes 0 then 1.
3. Both reqs held high for 4 frames -> grants alternate 0,1,0,1. No ack ever coincides with busy already high from a prior frame.
4. STOP_BITS=2, DATA_BITS=7, data1=7'h55 -> tx low for 1 period, bits 1,0,1,0,1,0,1, then high for 2 periods. Total 10 baud periods.
5. Reset driven low during DATA bit 3 -> tx=1 and busy=0 in the same clk, asynchronously. After release with no req, tx stays 1 and no ack appears.
6. baud_en from a real uart_clk_en (period 5301 clks), byte 8'h00 -> tx low for exactly 9×5301 clks after the ARM wait, then high for 5301 clks.
